column_drop_engine: RTL and testbench



---
 rtl/column_drop_engine.sv | 174 +++++++++++++++++
 tb/tb_column_drop_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/column_drop_engine.sv
// Connect4 column drop engine: holds per-column fill heights and serves req/ack drop requests.
// Optional undo history is built when the DROP_UNDO_EN macro is defined.
module column_drop_engine #(
  parameter int COLS  = 4,
  parameter int ROWS  = 4,
  parameter int HGT_W = 3,
  parameter int POS_W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [COLS-1:0]         sel_n,
  input  logic                    req,
  input  logic                    undo,
  output logic                    ack,
  output logic                    valid,
  output logic                    undone,
  output logic [POS_W-1:0]        column_position,
  output logic [COLS*HGT_W-1:0]   heights,
  output logic                    player,
  output logic                    board_full
);

  localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W  = $clog2(COLS + 1);

  typedef enum logic [1:0] {IDLE, EVAL, RESP, HOLD} state_t;

  state_t              r_state, w_next;
  logic [COLS-1:0]     r_sel;
  logic                r_undo_op;
  logic [HGT_W-1:0]    r_hgt [COLS];
  logic                r_ack, r_valid, r_undone, r_player, r_full;
  logic [POS_W-1:0]    r_pos;

  logic [CNT_W-1:0]    w_cnt;
  logic [CIDX_W-1:0]   w_col;
  logic [HGT_W-1:0]    w_hsel;
  logic                w_drop_ok, w_full, w_push, w_undo_in, w_undo_ok;
  logic [POS_W-1:0]    w_drop_pos, w_undo_pos;
  logic [CIDX_W-1:0]   w_top;
  logic [HGT_W-1:0]    w_uh;

  // Locate the single low bit of the captured select
  always_comb begin
    w_cnt = '0;
    w_col = '0;
    for (int i = 0; i < COLS; i++) begin
      if (!r_sel[i]) begin
        w_cnt = w_cnt + CNT_W'(1);
        w_col = CIDX_W'(i);
      end
    end
    w_hsel     = r_hgt[w_col];
    w_drop_ok  = enable && (w_cnt == CNT_W'(1)) && (w_hsel < HGT_W'(ROWS));
    w_drop_pos = POS_W'(w_hsel) * POS_W'(COLS) + POS_W'(w_col);
    w_push     = (r_state == EVAL) && !r_undo_op && w_drop_ok;
  end

  always_comb begin
    w_full = 1'b1;
    heights = '0;
    for (int i = 0; i < COLS; i++) begin
      heights[i*HGT_W +: HGT_W] = r_hgt[i];
      if (r_hgt[i] != HGT_W'(ROWS)) w_full = 1'b0;
    end
  end

`ifdef DROP_UNDO_EN
  localparam int CELLS = COLS * ROWS;
  localparam int SP_W  = $clog2(CELLS + 1);
  localparam int IDX_W = $clog2(CELLS);

  logic [CIDX_W-1:0] r_stk [CELLS];
  logic [SP_W-1:0]   r_sp;
  logic [IDX_W-1:0]  w_top_idx;

  assign w_undo_in  = undo;
  assign w_undo_ok  = (r_sp != '0);
  assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
  assign w_top      = r_stk[w_top_idx];
  assign w_uh       = r_hgt[w_top] - HGT_W'(1);
  assign w_undo_pos = POS_W'(w_uh) * POS_W'(COLS) + POS_W'(w_top);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_sp <= '0;
    end else if (r_state == EVAL) begin
      if (w_push)
        r_sp <= r_sp + SP_W'(1);
      else if (r_undo_op && w_undo_ok)
        r_sp <= r_sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_stk[r_sp[IDX_W-1:0]] <= w_col;
  end
`else
  logic w_unused_undo;
  assign w_unused_undo = undo;
  assign w_undo_in     = 1'b0;
  assign w_undo_ok     = 1'b0;
  assign w_top         = '0;
  assign w_uh          = '0;
  assign w_undo_pos    = '1;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (req || w_undo_in) w_next = EVAL;
      EVAL: w_next = RESP;
      RESP: w_next = r_undo_op ? IDLE : HOLD;
      HOLD: if (!req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && req) r_sel <= sel_n;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state   <= IDLE;
      r_undo_op <= 1'b0;
      r_ack     <= 1'b0;
      r_valid   <= 1'b0;
      r_undone  <= 1'b0;
      r_player  <= 1'b0;
      r_full    <= 1'b0;
      r_pos     <= '1;
      for (int i = 0; i < COLS; i++) r_hgt[i] <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= 1'b0;
      r_full  <= w_full;
      if (r_state == IDLE) begin
        if (req) r_undo_op <= 1'b0;
        else if (w_undo_in) r_undo_op <= 1'b1;
      end
      // Result is registered on the edge entering RESP, together with height/player updates
      if (r_state == EVAL) begin
        r_ack    <= 1'b1;
        r_undone <= r_undo_op;
        r_valid  <= 1'b0;
        r_pos    <= '1;
        if (r_undo_op) begin
          if (w_undo_ok) begin
            r_hgt[w_top] <= w_uh;
            r_player     <= ~r_player;
            r_valid      <= 1'b1;
            r_pos        <= w_undo_pos;
          end
        end else if (w_drop_ok) begin
          r_hgt[w_col] <= w_hsel + HGT_W'(1);
          r_player     <= ~r_player;
          r_valid      <= 1'b1;
          r_pos        <= w_drop_pos;
        end
      end
    end
  end

  assign ack             = r_ack;
  assign valid           = r_valid;
  assign undone          = r_undone;
  assign column_position = r_pos;
  assign player          = r_player;
  assign board_full      = r_full;

endmodule

// File: tb/tb_column_drop_engine.sv
// Directed bench for column_drop_engine (COLS=ROWS=4); undo steps are built when DROP_UNDO_EN is defined.
module tb_column_drop_engine;
  logic        clk = 1'b0;
  logic        reset, clear, enable, req, undo;
  logic [3:0]  sel_n;
  logic        ack, valid, undone, player, board_full;
  logic [4:0]  column_position;
  logic [11:0] heights;

  int   total = 0;
  int   bad = 0;
  int   eh [4];
  logic exp_player;
  logic full_after;

  column_drop_engine #(.COLS(4), .ROWS(4), .HGT_W(3), .POS_W(5)) dut (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .sel_n(sel_n),
    .req(req), .undo(undo), .ack(ack), .valid(valid), .undone(undone),
    .column_position(column_position), .heights(heights), .player(player),
    .board_full(board_full)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] packh();
    logic [11:0] h;
    h = '0;
    for (int i = 0; i < 4; i++) h[i*3 +: 3] = 3'(eh[i]);
    return h;
  endfunction

  task automatic wait_ack(output int lat);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      lat++;
      if (ack) break;
    end
  endtask

  task automatic drop(input string tag, input logic [3:0] sel, input int col, input logic [4:0] pos);
    int lat;
    sel_n = sel;
    req = 1'b1;
    wait_ack(lat);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_valid"}, valid, (col >= 0));
    chk({tag, "_pos"}, column_position, pos);
    chk({tag, "_undone"}, undone, 1'b0);
    if (col >= 0) begin
      eh[col]++;
      exp_player = ~exp_player;
    end
    chk({tag, "_heights"}, heights, packh());
    chk({tag, "_player"}, player, exp_player);
    req = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ackpulse"}, ack, 1'b0);
    full_after = board_full;
    @(posedge clk); #1;
  endtask

`ifdef DROP_UNDO_EN
  task automatic undo_op(input string tag, input int col, input logic [4:0] pos);
    int lat;
    undo = 1'b1;
    @(posedge clk); #1;
    undo = 1'b0;
    wait_ack(lat);
    chk({tag, "_lat"}, lat + 1, 2);
    chk({tag, "_valid"}, valid, (col >= 0));
    chk({tag, "_undone"}, undone, 1'b1);
    chk({tag, "_pos"}, column_position, pos);
    if (col >= 0) begin
      eh[col]--;
      exp_player = ~exp_player;
    end
    chk({tag, "_heights"}, heights, packh());
    chk({tag, "_player"}, player, exp_player);
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    int n, lat;
    logic [4:0] p;
    logic [3:0] s;
    reset = 1'b1; clear = 1'b0; enable = 1'b1; req = 1'b0; undo = 1'b0; sel_n = 4'b1111;
    exp_player = 1'b0;
    for (int i = 0; i < 4; i++) eh[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ack", ack, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_undone", undone, 1'b0);
    chk("rst_pos", column_position, 5'd31);
    chk("rst_heights", heights, 12'h000);
    chk("rst_player", player, 1'b0);
    chk("rst_full", board_full, 1'b0);

    drop("d0", 4'b1110, 0, 5'd0);
    chk("d0_heights_abs", heights, 12'h001);
    chk("d0_full", full_after, 1'b0);

    drop("c3a", 4'b0111, 3, 5'd3);
    drop("c3b", 4'b0111, 3, 5'd7);
    drop("c3c", 4'b0111, 3, 5'd11);
    drop("c3d", 4'b0111, 3, 5'd15);
    drop("c3over", 4'b0111, -1, 5'd31);

    drop("twozero", 4'b1100, -1, 5'd31);
    drop("nozero", 4'b1111, -1, 5'd31);
    enable = 1'b0;
    drop("disabled", 4'b1101, -1, 5'd31);
    enable = 1'b1;

    // Request held for many cycles yields one drop
    sel_n = 4'b1101; req = 1'b1; n = 0; p = '1;
    repeat (12) begin
      @(posedge clk); #1;
      if (ack) begin n++; p = column_position; end
    end
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    eh[1]++; exp_player = ~exp_player;
    chk("hold_acks", n, 1);
    chk("hold_pos", p, 5'd1);
    chk("hold_player", player, exp_player);

    // Select changes after capture are ignored
    sel_n = 4'b1011; req = 1'b1;
    @(posedge clk); #1;
    sel_n = 4'b1110;
    wait_ack(lat);
    chk("selchg_lat", lat, 1);
    chk("selchg_pos", column_position, 5'd2);
    eh[2]++; exp_player = ~exp_player;
    chk("selchg_heights", heights, packh());
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int r = 1; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        s = 4'b0001 << c;
        drop("fill", ~s, c, 5'(r * 4 + c));
      end
    end
    chk("full_after16", full_after, 1'b1);
    chk("full_heights", heights, 12'h924);
    chk("full_player", player, 1'b0);
    drop("full_rej", 4'b1110, -1, 5'd31);

    // Clear coincident with a request
    sel_n = 4'b1110; req = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; req = 1'b0; n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) n++;
    end
    for (int i = 0; i < 4; i++) eh[i] = 0;
    exp_player = 1'b0;
    chk("clr_acks", n, 0);
    chk("clr_heights", heights, 12'h000);
    chk("clr_full", board_full, 1'b0);
    chk("clr_pos", column_position, 5'd31);
    chk("clr_player", player, 1'b0);
    chk("clr_valid", valid, 1'b0);

    // Clear while the request is in EVAL
    sel_n = 4'b1110; req = 1'b1;
    @(posedge clk); #1;
    clear = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0; n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) n++;
    end
    chk("clreval_acks", n, 0);
    chk("clreval_heights", heights, 12'h000);
    chk("clreval_player", player, 1'b0);

`ifdef DROP_UNDO_EN
    drop("u_d1", 4'b1101, 1, 5'd1);
    drop("u_d2", 4'b1011, 2, 5'd2);
    undo_op("undo1", 2, 5'd2);
    chk("undo1_heights_abs", heights, 12'h008);
    chk("undo1_player_abs", player, 1'b1);
    undo_op("undo2", 1, 5'd1);
    undo_op("undo3", -1, 5'd31);
`else
    undo = 1'b1;
    @(posedge clk); #1;
    undo = 1'b0; n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) n++;
    end
    chk("undo_ign_acks", n, 0);
    chk("undo_ign_undone", undone, 1'b0);
    drop("post_clr", 4'b1110, 0, 5'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
